div_unit: RTL

- Iterative restoring divider in the EX stage; executes DIV/DIVU flagged by the decode stage's isDiv signal.
- Holds the pipeline via a stall output while it iterates, then delivers {remainder, quotient} for the HI/LO write, which the decode stage has already enabled with hilo_we.
- One quotient bit per cycle; supports signed and unsigned operation.

---
 rtl/cpu_defines.sv | 16 +
 rtl/div_step.sv | 32 +++
 rtl/div_unit.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/cpu_defines.sv
// Shared definitions for the EX-stage divide unit: state encoding,
// divide funct codes and the default datapath width.
package cpu_defines;

    localparam int DATA_W_DEF = 32;

    localparam logic [5:0] EXE_DIV  = 6'b011010;
    localparam logic [5:0] EXE_DIVU = 6'b011011;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quot} left by one, then
// subtract the divisor when the shifted remainder is large enough and
// record the outcome in the quotient LSB.
module div_step
    import cpu_defines::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W:0]   rem,
    input  logic [DATA_W-1:0] quot,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W:0]   rem_next,
    output logic [DATA_W-1:0] quot_next
);

    logic [DATA_W+1:0] shifted_s;
    logic              fits_s;

    // Trial subtraction; the extra top bit keeps the compare exact.
    always_comb begin
        shifted_s = {rem, quot[DATA_W-1]};
        fits_s    = (shifted_s >= {2'b00, divisor});
        if (fits_s) begin
            rem_next  = shifted_s[DATA_W:0] - {1'b0, divisor};
            quot_next = {quot[DATA_W-2:0], 1'b1};
        end else begin
            rem_next  = shifted_s[DATA_W:0];
            quot_next = {quot[DATA_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU. Stalls the pipeline while it
// iterates (one quotient bit per cycle) and then presents the remainder
// on hi_out and the quotient on lo_out with ready for the HI/LO write.
module div_unit
    import cpu_defines::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              signed_div,
    input  logic [DATA_W-1:0] opa,
    input  logic [DATA_W-1:0] opb,
    input  logic              flush,
    input  logic              pipe_stall,
    output logic              div_stall,
    output logic              ready,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Two's complement negation when neg is set, identity otherwise.
    function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v,
                                                   input logic              neg);
        if (neg) begin
            cond_neg = ~v + {{(DATA_W-1){1'b0}}, 1'b1};
        end else begin
            cond_neg = v;
        end
    endfunction

    div_state_e        state_r, state_next_s;
    logic [DATA_W:0]   rem_r, rem_next_s;
    logic [DATA_W-1:0] quot_r, quot_next_s;
    logic [DATA_W-1:0] divisor_r, divisor_next_s;
    logic [CNT_W-1:0]  cnt_r, cnt_next_s;
    logic              quot_neg_r, quot_neg_next_s;
    logic              rem_neg_r, rem_neg_next_s;
    logic              ready_r, ready_next_s;
    logic [DATA_W-1:0] hi_r, hi_next_s;
    logic [DATA_W-1:0] lo_r, lo_next_s;
    logic              div_stall_s;
    logic [DATA_W:0]   step_rem_s;
    logic [DATA_W-1:0] step_quot_s;

    div_step #(.DATA_W(DATA_W)) u_step (
        .rem       (rem_r),
        .quot      (quot_r),
        .divisor   (divisor_r),
        .rem_next  (step_rem_s),
        .quot_next (step_quot_s)
    );

    // Next-state, datapath updates and the combinational stall request.
    always_comb begin
        state_next_s    = state_r;
        rem_next_s      = rem_r;
        quot_next_s     = quot_r;
        divisor_next_s  = divisor_r;
        cnt_next_s      = cnt_r;
        quot_neg_next_s = quot_neg_r;
        rem_neg_next_s  = rem_neg_r;
        hi_next_s       = hi_r;
        lo_next_s       = lo_r;
        ready_next_s    = 1'b0;
        div_stall_s     = 1'b0;

        if (flush) begin
            // Cancelled instruction: drop everything, keep old results.
            state_next_s = DIV_IDLE;
        end else begin
            case (state_r)
                DIV_IDLE: begin
                    if (start) begin
                        div_stall_s = 1'b1;
                        if (opb == {DATA_W{1'b0}}) begin
                            // Divide by zero completes at once with fixed results.
                            state_next_s = DIV_DONE;
                            hi_next_s    = opa;
                            lo_next_s    = {DATA_W{1'b1}};
                            ready_next_s = 1'b1;
                        end else begin
                            state_next_s    = DIV_BUSY;
                            quot_next_s     = cond_neg(opa, signed_div & opa[DATA_W-1]);
                            divisor_next_s  = cond_neg(opb, signed_div & opb[DATA_W-1]);
                            quot_neg_next_s = signed_div & (opa[DATA_W-1] ^ opb[DATA_W-1]);
                            rem_neg_next_s  = signed_div & opa[DATA_W-1];
                            rem_next_s      = {(DATA_W+1){1'b0}};
                            cnt_next_s      = {CNT_W{1'b0}};
                        end
                    end else begin
                        state_next_s = DIV_IDLE;
                    end
                end
                DIV_BUSY: begin
                    div_stall_s = 1'b1;
                    rem_next_s  = step_rem_s;
                    quot_next_s = step_quot_s;
                    cnt_next_s  = cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        state_next_s = DIV_DONE;
                        hi_next_s    = cond_neg(step_rem_s[DATA_W-1:0], rem_neg_r);
                        lo_next_s    = cond_neg(step_quot_s, quot_neg_r);
                        ready_next_s = 1'b1;
                    end else begin
                        state_next_s = DIV_BUSY;
                    end
                end
                DIV_DONE: begin
                    // A start seen here is the same held instruction; ignore it.
                    if (pipe_stall) begin
                        state_next_s = DIV_DONE;
                        ready_next_s = 1'b1;
                    end else begin
                        state_next_s = DIV_IDLE;
                    end
                end
                default: begin
                    state_next_s = DIV_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= DIV_IDLE;
            rem_r      <= {(DATA_W+1){1'b0}};
            quot_r     <= {DATA_W{1'b0}};
            divisor_r  <= {DATA_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            quot_neg_r <= 1'b0;
            rem_neg_r  <= 1'b0;
            ready_r    <= 1'b0;
            hi_r       <= {DATA_W{1'b0}};
            lo_r       <= {DATA_W{1'b0}};
        end else begin
            state_r    <= state_next_s;
            rem_r      <= rem_next_s;
            quot_r     <= quot_next_s;
            divisor_r  <= divisor_next_s;
            cnt_r      <= cnt_next_s;
            quot_neg_r <= quot_neg_next_s;
            rem_neg_r  <= rem_neg_next_s;
            ready_r    <= ready_next_s;
            hi_r       <= hi_next_s;
            lo_r       <= lo_next_s;
        end
    end

    assign div_stall = div_stall_s;
    assign ready     = ready_r;
    assign hi_out    = hi_r;
    assign lo_out    = lo_r;

endmodule
